// File: rtl/rtc_bus_pkg.sv
// Shared types and timing constants for the RTC multiplexed bus-cycle engine.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STRB, A_HOLD, GAP, D_SETUP, D_STRB, D_HOLD, DONE
  } bus_state_t;

  localparam int unsigned DEF_T_SETUP  = 2;
  localparam int unsigned DEF_T_STROBE = 10;
  localparam int unsigned DEF_T_HOLD   = 2;
  localparam int unsigned DEF_T_GAP    = 4;

  // Cycle (counted from the accept edge) on which done is asserted.
  function automatic int unsigned cycle_len(input int unsigned s, input int unsigned st,
                                            input int unsigned h, input int unsigned g);
    return 2 * (s + st + h) + g + 1;
  endfunction

  localparam int unsigned DEF_CYCLE_LEN =
    cycle_len(DEF_T_SETUP, DEF_T_STROBE, DEF_T_HOLD, DEF_T_GAP);

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; holds at zero once expired.
module rtc_phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// RTC multiplexed address/data bus-cycle engine with registered strobes.
// Optional RTC_BUS_RDATA_SYNC_EN adds a 2-flop synchronizer on ad_in.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP  = DEF_T_SETUP,
  parameter int unsigned T_STROBE = DEF_T_STROBE,
  parameter int unsigned T_HOLD   = DEF_T_HOLD,
  parameter int unsigned T_GAP    = DEF_T_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int unsigned CW = $clog2(max4(T_SETUP, T_STROBE, T_HOLD, T_GAP)) + 1;
  localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP    = CW'(T_GAP - 1);

  bus_state_t    state, next_state;
  logic          load, expired;
  logic [CW-1:0] load_value;
  logic          we_l, we_d;
  logic [7:0]    addr_l, addr_d, wdata_l, wdata_d;
  logic [7:0]    sample;

  rtc_phase_timer #(.WIDTH(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .expired    (expired)
  );

`ifdef RTC_BUS_RDATA_SYNC_EN
  logic [7:0] sync1, sync2;

  if (T_STROBE < 3) begin : g_strobe_too_short
    $error("T_STROBE must be at least 3 when the rdata synchronizer is enabled");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ad_in;
      sync2 <= sync1;
    end
  end
  assign sample = sync2;
`else
  assign sample = ad_in;
`endif

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_value = '0;
    unique case (state)
      IDLE:    if (req)     begin next_state = A_SETUP; load = 1'b1; load_value = LD_SETUP;  end
      A_SETUP: if (expired) begin next_state = A_STRB;  load = 1'b1; load_value = LD_STROBE; end
      A_STRB:  if (expired) begin next_state = A_HOLD;  load = 1'b1; load_value = LD_HOLD;   end
      A_HOLD:  if (expired) begin next_state = GAP;     load = 1'b1; load_value = LD_GAP;    end
      GAP:     if (expired) begin next_state = D_SETUP; load = 1'b1; load_value = LD_SETUP;  end
      D_SETUP: if (expired) begin next_state = D_STRB;  load = 1'b1; load_value = LD_STROBE; end
      D_STRB:  if (expired) begin next_state = D_HOLD;  load = 1'b1; load_value = LD_HOLD;   end
      D_HOLD:  if (expired) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode the upcoming state, so the accept edge must see the fresh request fields.
  always_comb begin
    we_d    = we_l;
    addr_d  = addr_l;
    wdata_d = wdata_l;
    if (state == IDLE && req) begin
      we_d    = we;
      addr_d  = addr;
      wdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d_n   <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= '0;
    end else begin
      state   <= next_state;
      we_l    <= we_d;
      addr_l  <= addr_d;
      wdata_l <= wdata_d;
      if (state == D_STRB && expired && !we_l)
        rdata <= sample;

      busy   <= 1'b1;
      done   <= 1'b0;
      cs_n   <= 1'b0;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d_n  <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= '0;
      unique case (next_state)
        IDLE: begin
          busy <= 1'b0;
          cs_n <= 1'b1;
        end
        A_SETUP, A_HOLD: begin
          a_d_n  <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= addr_d;
        end
        A_STRB: begin
          a_d_n  <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= addr_d;
          wr_n   <= 1'b0;
        end
        GAP: ;
        D_SETUP, D_HOLD: begin
          if (we_d) begin
            ad_oe  <= 1'b1;
            ad_out <= wdata_d;
          end
        end
        D_STRB: begin
          if (we_d) begin
            ad_oe  <= 1'b1;
            ad_out <= wdata_d;
            wr_n   <= 1'b0;
          end else begin
            rd_n   <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b1;
          cs_n <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
          cs_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: default and minimum-timing instances against a phase-arithmetic model.
module tb_rtc_bus_cycle;
  import rtc_bus_pkg::*;

`ifdef RTC_BUS_RDATA_SYNC_EN
  localparam int unsigned F_STROBE = 3;
  localparam int          F_DONE   = 12;
  localparam bit          SYNC     = 1'b1;
`else
  localparam int unsigned F_STROBE = 1;
  localparam int          F_DONE   = 8;
  localparam bit          SYNC     = 1'b0;
`endif

  localparam int unsigned PS [2] = '{DEF_T_SETUP, 1};
  localparam int unsigned PST[2] = '{DEF_T_STROBE, F_STROBE};
  localparam int unsigned PH [2] = '{DEF_T_HOLD, 1};
  localparam int unsigned PG [2] = '{DEF_T_GAP, 1};

  logic       clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [7:0] addr = '0, wdata = '0, ad_in = '0;
  logic       busy [2], done [2], cs_n [2], rd_n [2], wr_n [2], a_d_n [2], ad_oe [2];
  logic [7:0] rdata [2], ad_out [2];

  always #5 clk = ~clk;

  rtc_bus_cycle #(.T_SETUP(DEF_T_SETUP), .T_STROBE(DEF_T_STROBE),
                  .T_HOLD(DEF_T_HOLD), .T_GAP(DEF_T_GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]),
    .wr_n(wr_n[0]), .a_d_n(a_d_n[0]), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .ad_in(ad_in)
  );

  rtc_bus_cycle #(.T_SETUP(1), .T_STROBE(F_STROBE), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]),
    .wr_n(wr_n[1]), .a_d_n(a_d_n[1]), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .ad_in(ad_in)
  );

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  bit m_active [2] = '{1'b0, 1'b0};
  int m_acc [2] = '{0, 0};
  bit m_we [2] = '{1'b0, 1'b0};
  logic [7:0] m_addr [2], m_wdata [2], m_rdata [2];
  logic [7:0] adh1 = '0, adh2 = '0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  function automatic int done_cyc(input int i);
    return int'(cycle_len(PS[i], PST[i], PH[i], PG[i]));
  endfunction

  function automatic int dstrb_last(input int i);
    return int'(2 * PS[i] + 2 * PST[i] + PH[i] + PG[i]);
  endfunction

  // 0 idle, 1..3 address setup/strobe/hold, 4 gap, 5..7 data setup/strobe/hold, 8 done.
  function automatic int phase(input int k, input int i);
    int s, st, h, g, p;
    s = int'(PS[i]); st = int'(PST[i]); h = int'(PH[i]); g = int'(PG[i]);
    p = s + st + h;
    if (k < 1) return 0;
    if (k <= s) return 1;
    if (k <= s + st) return 2;
    if (k <= p) return 3;
    if (k <= p + g) return 4;
    if (k <= p + g + s) return 5;
    if (k <= p + g + s + st) return 6;
    if (k <= 2 * p + g) return 7;
    if (k == 2 * p + g + 1) return 8;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] smp;
    int kc;
    smp = SYNC ? adh2 : ad_in;
    for (int i = 0; i < 2; i++) begin
      kc = cyc - m_acc[i];
      if (reset) begin
        m_active[i] = 1'b0;
        m_rdata[i]  = '0;
      end else if (m_active[i]) begin
        if (!m_we[i] && kc == dstrb_last(i)) m_rdata[i] = smp;
        if (kc == done_cyc(i)) m_active[i] = 1'b0;
      end else if (req) begin
        m_active[i] = 1'b1;
        m_acc[i]    = cyc;
        m_we[i]     = we;
        m_addr[i]   = addr;
        m_wdata[i]  = wdata;
      end
    end
    adh2 = adh1;
    adh1 = ad_in;
    cyc++;
  end

  always @(negedge clk) begin : compare
    int p;
    bit e_oe;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        p = m_active[i] ? phase(cyc - m_acc[i], i) : 0;
        e_oe = (p >= 1 && p <= 3) || (m_we[i] && p >= 5 && p <= 7);
        chk("busy",  i, busy[i],  p != 0);
        chk("done",  i, done[i],  p == 8);
        chk("cs_n",  i, cs_n[i],  !(p >= 1 && p <= 7));
        chk("a_d_n", i, a_d_n[i], !(p >= 1 && p <= 3));
        chk("ad_oe", i, ad_oe[i], e_oe);
        chk("wr_n",  i, wr_n[i],  !(p == 2 || (m_we[i] && p == 6)));
        chk("rd_n",  i, rd_n[i],  !(!m_we[i] && p == 6));
        chk("rdata", i, rdata[i], m_rdata[i]);
        if (e_oe) chk("ad_out", i, ad_out[i], (p <= 3) ? m_addr[i] : m_wdata[i]);
      end
    end
  end

  initial begin
    int n_addr, n_awr, n_dwr, n_rd, n_oe, n_done, done_at, done_at_f;
    logic [7:0] rd_val;

    repeat (3) @(negedge clk);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("rst_rdata", 0, rdata[0], 8'h00);
    chk("rst_strobes", 0, {cs_n[0], rd_n[0], wr_n[0], a_d_n[0]}, 4'b1111);
    chk("rst_ad_oe", 0, ad_oe[0], 0);
    chk("rst_ad_out", 0, ad_out[0], 8'h00);
    chk_en = 1'b1;
    reset = 1'b0;

    // Write with default timing.
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 8'h21; wdata = 8'h45;
    n_addr = 0; n_awr = 0; n_dwr = 0; n_rd = 0; done_at = -1; done_at_f = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (!a_d_n[0] && ad_oe[0] && ad_out[0] == 8'h21) n_addr++;
      if (!wr_n[0] && !a_d_n[0] && ad_out[0] == 8'h21) n_awr++;
      if (!wr_n[0] && a_d_n[0] && ad_out[0] == 8'h45) n_dwr++;
      if (!rd_n[0]) n_rd++;
      if (done[0]) done_at = k;
      if (done[1]) done_at_f = k;
    end
    chk("wr_addr_cycles", 0, n_addr, 14);
    chk("wr_addr_strobe", 0, n_awr, 10);
    chk("wr_data_strobe", 0, n_dwr, 10);
    chk("wr_rd_n_low", 0, n_rd, 0);
    chk("wr_done_cycle", 0, done_at, 33);
    chk("fast_done_cycle", 1, done_at_f, F_DONE);

    // Read, bus returns 8'h59 during the data strobe.
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 8'h22; ad_in = 8'($urandom);
    n_oe = 0; n_rd = 0; done_at = -1; rd_val = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (ad_oe[0] && k >= 19 && k <= 32) n_oe++;
      if (!rd_n[0]) n_rd++;
      if (done[0]) begin done_at = k; rd_val = rdata[0]; end
      ad_in = (k >= 21 && k <= 30) ? 8'h59 : 8'($urandom);
    end
    chk("rd_oe_data_phase", 0, n_oe, 0);
    chk("rd_strobe_cycles", 0, n_rd, 10);
    chk("rd_done_cycle", 0, done_at, 33);
    chk("rd_value", 0, rd_val, 8'h59);

    // Reset during the write data strobe.
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 8'($urandom); wdata = 8'($urandom);
    n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 25) reset = 1'b1;
      if (k == 26) begin
        chk("rst_mid_cs_n", 0, cs_n[0], 1);
        chk("rst_mid_wr_n", 0, wr_n[0], 1);
        chk("rst_mid_ad_oe", 0, ad_oe[0], 0);
        chk("rst_mid_busy", 0, busy[0], 0);
        reset = 1'b0;
      end
      if (done[0]) n_done++;
    end
    chk("rst_mid_no_done", 0, n_done, 0);

    // Bus changes on the last strobe cycle; synchronized capture lags by two cycles.
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 8'h23;
    rd_val = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (done[0]) rd_val = rdata[0];
      ad_in = (k >= 21 && k <= 29) ? 8'hAA : (k == 30) ? 8'h33 : 8'($urandom);
    end
    chk("sync_rdata", 0, rd_val, SYNC ? 8'hAA : 8'h33);

    // Request held high: one transaction, next accept in the idle cycle after done.
    @(negedge clk); req = 1'b1; we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 34 && done[0]) n_done++;
      if (k == 34) chk("held_idle_gap", 0, busy[0], 0);
      if (k == 35) begin
        chk("held_reaccept_busy", 0, busy[0], 1);
        chk("held_reaccept_cs_n", 0, cs_n[0], 0);
      end
    end
    chk("held_one_txn", 0, n_done, 1);
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      req   = ($urandom_range(0, 3) == 0);
      we    = 1'($urandom);
      addr  = 8'($urandom);
      wdata = 8'($urandom);
      ad_in = 8'($urandom);
    end
    reset = 1'b0; req = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle engine for the RTC's multiplexed 8-bit address/data port. It sits directly downstream of the machine-select/address-data mux. It accepts one transaction request, either a register write or a register read. It then generates the chip-select, read, write and address/data strobes with programmable phase lengths, drives or samples the shared bus, and returns read data with a one-cycle completion pulse to the register bank.

## Interface
Parameters:
- T_SETUP, 2: cycles that address or data is valid before a strobe; minimum 1.
- T_STROBE, 10: cycles a strobe is held low; minimum 1, or minimum 3 when RTC_BUS_RDATA_SYNC_EN is defined.
- T_HOLD, 2: cycles that address or data is held after a strobe rises; minimum 1.
- T_GAP, 4: idle cycles between the address phase and the data phase; minimum 1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: reset, synchronous, active-high.
- req, in, 1: transaction request; sampled only in IDLE.
- we, in, 1: 1 = write, 0 = read; latched on accept.
- addr, in, 8: RTC register address; latched on accept.
- wdata, in, 8: write data; latched on accept.
- busy, out, 1: transaction in progress.
- done, out, 1: one-cycle completion pulse.
- rdata, out, 8: last read value; holds until the next read completes.
- cs_n, out, 1: chip select, active low.
- rd_n, out, 1: read strobe, active low.
- wr_n, out, 1: write/address-latch strobe, active low.
- a_d_n, out, 1: 0 = address on bus, 1 = data on bus.
- ad_out, out, 8: bus drive value.
- ad_oe, out, 1: bus drive enable; the tristate buffer lives in the top level.
- ad_in, in, 8: bus sample value.

## Operation
- States: IDLE, A_SETUP, A_STRB, A_HOLD, GAP, D_SETUP, D_STRB, D_HOLD, DONE.
- IDLE to A_SETUP when req=1. On that edge addr, wdata and we are latched.
- Each timed state lasts exactly its parameter count of cycles, then advances to the next state in order.
- DONE lasts 1 cycle, then the FSM returns to IDLE.
- Address phase (A_SETUP, A_STRB, A_HOLD): cs_n=0, a_d_n=0, ad_oe=1, ad_out=latched addr. wr_n=0 only in A_STRB.
- GAP: cs_n=0, a_d_n=1, ad_oe=0, all strobes high.
- Write data phase (D_SETUP, D_STRB, D_HOLD): cs_n=0, a_d_n=1, ad_oe=1, ad_out=latched wdata. wr_n=0 only in D_STRB.
- Read data phase: ad_oe=0 for the whole phase. rd_n=0 only in D_STRB. rdata is captured on the last cycle of D_STRB.
- IDLE and DONE: cs_n=rd_n=wr_n=a_d_n=1, ad_oe=0.
- req while busy=1 is ignored; nothing is queued.
- Reset, at any point mid-cycle: on the next edge the FSM enters IDLE, all strobes go high, ad_oe=0, busy=0, and no done pulse is produced. rdata is cleared.
- Reset values: busy=0, done=0, rdata=8'h00, cs_n=rd_n=wr_n=a_d_n=1, ad_oe=0, ad_out=8'h00.
- Phase counter: width $clog2 of the largest parameter plus 1. It is loaded with param−1 on state entry and the state advances when it reaches 0. There is no wrap-around.

## Timing
- All outputs are registered; strobe edges are glitch-free.
- Accept edge is cycle 0. From cycle 1: cs_n=0 and busy=1.
- done=1 at cycle 2·(T_SETUP+T_STROBE+T_HOLD)+T_GAP+1, which is cycle 33 with the defaults.
- busy=0 in the cycle after done.
- rdata is valid in the same cycle as done.
- Back-to-back: the earliest next accept is in the IDLE cycle following DONE, so one gap cycle is guaranteed between transactions.

## Configuration
- RTC_BUS_RDATA_SYNC_EN defined: ad_in passes through a 2-flop synchronizer. rdata is captured from the synchronized value at the same point (last cycle of D_STRB), so it reflects bus data from 2 cycles into the strobe earlier. T_STROBE ≥ 3 is required and is checked by an elaboration assertion.
- RTC_BUS_RDATA_SYNC_EN undefined: ad_in is sampled directly, with no synchronizer flops.

## Structure
- rtc_bus_pkg holds:
  - the state enum;
  - the default timing constants;
  - the localparam formula for total cycle length, which the bench uses.
- One sub-module, rtc_phase_timer: a loadable down-counter with load value, load strobe and expire flag, instantiated once.

## Test plan
- Write, defaults. Stimulus: req=1, we=1, addr=8'h21, wdata=8'h45. Response:
  - ad_out=8'h21 with a_d_n=0 for 14 cycles, and wr_n low for 10 of them;
  - ad_out=8'h45 with wr_n low for 10 cycles;
  - done at cycle 33, rd_n high throughout.
- Read. Stimulus: req=1, we=0, addr=8'h22; the bench drives ad_in=8'h59 during D_STRB. Response: ad_oe=0 throughout the data phase, rd_n low for 10 cycles, rdata=8'h59 with done.
- Reset in D_STRB of a write. Response: the next cycle has cs_n=wr_n=1, ad_oe=0, busy=0; done is never asserted.
- req held high for 40 cycles. Response: exactly one transaction in the first 34 cycles; the second accept happens in the IDLE cycle after done.
- Parameter override T_SETUP=1, T_STROBE=1, T_HOLD=1, T_GAP=1. Response: done at cycle 8 and every phase is 1 cycle wide.
- With RTC_BUS_RDATA_SYNC_EN: ad_in changes from 8'hAA to 8'h33 on the last D_STRB cycle. Response: rdata=8'hAA. Without the macro: rdata=8'h33.
